// File: rtl/logic_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// logic_pkg : op-codes and frame-state encoding for the bitwise logic pipeline
// Rev 1.0
// ---------------------------------------------------------------------------
package logic_pkg;

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;
  localparam logic [1:0] OP_NAND = 2'b11;

  typedef enum logic [0:0] {
    ST_FIRST = 1'b0,
    ST_MID   = 1'b1
  } frame_state_e;

endpackage
`default_nettype wire

// File: rtl/logic_op_core.sv
`default_nettype none
// ---------------------------------------------------------------------------
// logic_op_core : combinational WIDTH-bit AND/OR/XOR/NAND of two operands
// Rev 1.0
// ---------------------------------------------------------------------------
module logic_op_core
  import logic_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] op_a_i,
  input  logic [WIDTH-1:0] op_b_i,
  input  logic [1:0]       op_i,
  output logic [WIDTH-1:0] y_o
);

  always_comb begin
    y_o = '0;
    case (op_i)
      OP_AND:  y_o = op_a_i & op_b_i;
      OP_OR:   y_o = op_a_i | op_b_i;
      OP_XOR:  y_o = op_a_i ^ op_b_i;
      OP_NAND: y_o = ~(op_a_i & op_b_i);
      default: y_o = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/logic_reduce_pipe.sv
`default_nettype none
// ---------------------------------------------------------------------------
// logic_reduce_pipe : 2-stage valid/ready bitwise logic unit with frame
// accumulator and AND/OR reduction flags. Define LOGIC_REDUCE_PARITY_EN to
// add the out_parity flag.  Rev 1.0
// ---------------------------------------------------------------------------
module logic_reduce_pipe
  import logic_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_op,
  input  logic             in_acc,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic             out_all,
  output logic             out_any,
`ifdef LOGIC_REDUCE_PARITY_EN
  output logic             out_parity,
`endif
  output logic             out_last
);

  frame_state_e     state_q;
  logic [WIDTH-1:0] acc_q;

  logic             s1_valid_q;
  logic [WIDTH-1:0] s1_y_q;
  logic             s1_last_q;
  logic [WIDTH-1:0] s1_y_d;

  logic             s2_valid_q;
  logic [WIDTH-1:0] s2_y_q;
  logic             s2_last_q;
  logic             s2_all_q;
  logic             s2_any_q;
  logic             s2_parity_q;

  logic             s2_adv;
  logic             accept;
  logic [WIDTH-1:0] op_a;

  assign s2_adv   = !s2_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s2_adv;
  assign accept   = in_valid && in_ready;

  // The accumulator only replaces A inside a frame; the first beat always uses in_a.
  assign op_a = (state_q == ST_MID && in_acc) ? acc_q : in_a;

  logic_op_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .op_a_i (op_a),
    .op_b_i (in_b),
    .op_i   (in_op),
    .y_o    (s1_y_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_FIRST;
      acc_q       <= '0;
      s1_valid_q  <= 1'b0;
      s1_y_q      <= '0;
      s1_last_q   <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_y_q      <= '0;
      s2_last_q   <= 1'b0;
      s2_all_q    <= 1'b0;
      s2_any_q    <= 1'b0;
      s2_parity_q <= 1'b0;
    end else begin
      if (s2_adv) begin
        s2_valid_q  <= s1_valid_q;
        s2_y_q      <= s1_y_q;
        s2_last_q   <= s1_last_q;
        s2_all_q    <= &s1_y_q;
        s2_any_q    <= |s1_y_q;
        s2_parity_q <= ^s1_y_q;
      end
      if (in_ready) begin
        s1_valid_q <= in_valid;
      end
      if (accept) begin
        s1_y_q    <= s1_y_d;
        s1_last_q <= in_last;
        acc_q     <= s1_y_d;
        case (state_q)
          ST_FIRST: state_q <= in_last ? ST_FIRST : ST_MID;
          ST_MID:   state_q <= in_last ? ST_FIRST : ST_MID;
          default:  state_q <= ST_FIRST;
        endcase
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign out_y     = s2_y_q;
  assign out_last  = s2_last_q;
  assign out_all   = s2_all_q;
  assign out_any   = s2_any_q;

`ifdef LOGIC_REDUCE_PARITY_EN
  assign out_parity = s2_parity_q;
`else
  logic unused_parity;
  assign unused_parity = s2_parity_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_logic_reduce_pipe.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_logic_reduce_pipe : self-checking bench for logic_reduce_pipe (WIDTH=8)
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_logic_reduce_pipe;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic [1:0]   in_op;
  logic         in_acc;
  logic         in_last;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_y;
  logic         out_all;
  logic         out_any;
  logic         out_last;
`ifdef LOGIC_REDUCE_PARITY_EN
  logic         out_parity;
`endif

  logic_reduce_pipe #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_op      (in_op),
    .in_acc     (in_acc),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_y      (out_y),
    .out_all    (out_all),
    .out_any    (out_any),
`ifdef LOGIC_REDUCE_PARITY_EN
    .out_parity (out_parity),
`endif
    .out_last   (out_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] op;
    logic       acc;
    logic       last;
    logic [7:0] y;
    logic       all_f;
    logic       any_f;
  } vec_t;

  vec_t vecs[12];

  int errors = 0;
  int checks = 0;
  int delivered = 0;

  // Reference model state: inside-frame flag, accumulator, in-flight beats {last, y}
  bit         m_mid;
  logic [7:0] m_acc;
  logic [8:0] q[$];
  bit         hold_pend;
  logic [7:0] hold_y;
  logic       hold_last;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] ref_op(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
    case (op)
      2'd0:    return a & b;
      2'd1:    return a | b;
      2'd2:    return a ^ b;
      default: return ~(a & b);
    endcase
  endfunction

  task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b,
                       input logic [1:0] op, input logic acc, input logic last);
    in_valid = v; in_a = a; in_b = b; in_op = op; in_acc = acc; in_last = last;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 8'h00, 8'h00, 2'd0, 1'b0, 1'b0);
    out_ready = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    m_mid = 1'b0; m_acc = 8'h00; q.delete(); hold_pend = 1'b0;
  endtask

  // One clock of scoreboarded traffic; inputs must already be set for this cycle.
  task automatic step(output bit ahs);
    logic [8:0] e;
    logic [7:0] oa;
    logic [7:0] y;
    #1;
    ahs = in_valid && in_ready;
    check("in_ready", {63'd0, in_ready}, (q.size() == 2 && !out_ready) ? 64'd0 : 64'd1);
    if (hold_pend) begin
      check("hold_valid", {63'd0, out_valid}, 64'd1);
      check("hold_y", {56'd0, out_y}, {56'd0, hold_y});
      check("hold_last", {63'd0, out_last}, {63'd0, hold_last});
    end
`ifdef LOGIC_REDUCE_PARITY_EN
    if (out_valid) check("parity", {63'd0, out_parity}, {63'd0, ^out_y});
`endif
    if (out_valid && out_ready) begin
      delivered++;
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL extra_beat: got out_y %0h expected no beat", out_y);
      end else begin
        e = q.pop_front();
        check("sb_y", {56'd0, out_y}, {56'd0, e[7:0]});
        check("sb_last", {63'd0, out_last}, {63'd0, e[8]});
        check("sb_all", {63'd0, out_all}, {63'd0, e[7:0] == 8'hFF});
        check("sb_any", {63'd0, out_any}, {63'd0, e[7:0] != 8'h00});
      end
    end
    hold_pend = out_valid && !out_ready;
    hold_y    = out_y;
    hold_last = out_last;
    if (ahs) begin
      oa = (m_mid && in_acc) ? m_acc : in_a;
      y  = ref_op(oa, in_b, in_op);
      q.push_back({in_last, y});
      m_acc = y;
      m_mid = !in_last;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    bit ahs;
    int sent;
    logic [7:0] bp_a[6];
    logic [7:0] bp_b[6];
    logic [1:0] bp_op[6];
    logic       bp_acc[6];
    logic       pat[6];

    vecs[0]  = '{8'hF0, 8'h3C, 2'd0, 1'b0, 1'b1, 8'h30, 1'b0, 1'b1};
    vecs[1]  = '{8'hF0, 8'h3C, 2'd1, 1'b0, 1'b1, 8'hFC, 1'b0, 1'b1};
    vecs[2]  = '{8'hF0, 8'h3C, 2'd2, 1'b0, 1'b1, 8'hCC, 1'b0, 1'b1};
    vecs[3]  = '{8'hF0, 8'h3C, 2'd3, 1'b0, 1'b1, 8'hCF, 1'b0, 1'b1};
    vecs[4]  = '{8'hFF, 8'hFF, 2'd0, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b1};
    vecs[5]  = '{8'h00, 8'h5A, 2'd0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
    vecs[6]  = '{8'hFF, 8'hF7, 2'd0, 1'b0, 1'b0, 8'hF7, 1'b0, 1'b1};
    vecs[7]  = '{8'h00, 8'h7F, 2'd0, 1'b1, 1'b0, 8'h77, 1'b0, 1'b1};
    vecs[8]  = '{8'h00, 8'hFE, 2'd0, 1'b1, 1'b1, 8'h76, 1'b0, 1'b1};
    vecs[9]  = '{8'h0F, 8'hFF, 2'd0, 1'b1, 1'b1, 8'h0F, 1'b0, 1'b1};
    vecs[10] = '{8'h07, 8'hFF, 2'd0, 1'b0, 1'b1, 8'h07, 1'b0, 1'b1};
    vecs[11] = '{8'h03, 8'hFF, 2'd0, 1'b0, 1'b1, 8'h03, 1'b0, 1'b1};

    // Reset state
    rst = 1'b1; out_ready = 1'b1;
    drive(1'b0, 8'h00, 8'h00, 2'd0, 1'b0, 1'b0);
    repeat (2) begin @(posedge clk); #1; end
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_y", {56'd0, out_y}, 64'd0);
    check("rst_flags", {61'd0, out_all, out_any, out_last}, 64'd0);
    rst = 1'b0;
    #1;
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);

    // Table vectors streamed back to back; beat i must appear exactly after edge i+1
    for (int i = 0; i <= 12; i++) begin
      if (i < 12) drive(1'b1, vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].acc, vecs[i].last);
      else        drive(1'b0, 8'h00, 8'h00, 2'd0, 1'b0, 1'b0);
      @(posedge clk); #1;
      if (i == 0) begin
        check("lat_no_early_valid", {63'd0, out_valid}, 64'd0);
      end else begin
        check("vec_valid", {63'd0, out_valid}, 64'd1);
        check("vec_y", {56'd0, out_y}, {56'd0, vecs[i-1].y});
        check("vec_all", {63'd0, out_all}, {63'd0, vecs[i-1].all_f});
        check("vec_any", {63'd0, out_any}, {63'd0, vecs[i-1].any_f});
        check("vec_last", {63'd0, out_last}, {63'd0, vecs[i-1].last});
`ifdef LOGIC_REDUCE_PARITY_EN
        check("vec_parity", {63'd0, out_parity}, {63'd0, ^vecs[i-1].y});
`endif
      end
    end
    @(posedge clk); #1;
    check("drained_valid", {63'd0, out_valid}, 64'd0);

    // Reset in the middle of an accumulate frame with a beat sitting in S2
    do_reset();
    drive(1'b1, 8'hFF, 8'hF7, 2'd0, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive(1'b1, 8'h00, 8'h7F, 2'd0, 1'b1, 1'b0);
    @(posedge clk); #1;
    check("mid_s2_valid", {63'd0, out_valid}, 64'd1);
    check("mid_s2_y", {56'd0, out_y}, 64'hF7);
    rst = 1'b1;
    drive(1'b0, 8'h00, 8'h00, 2'd0, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("mid_rst_valid", {63'd0, out_valid}, 64'd0);
    check("mid_rst_y", {56'd0, out_y}, 64'd0);
    check("mid_rst_flags", {61'd0, out_all, out_any, out_last}, 64'd0);
    rst = 1'b0;
    #1;
    check("mid_rst_in_ready", {63'd0, in_ready}, 64'd1);
    drive(1'b1, 8'h11, 8'hFF, 2'd0, 1'b1, 1'b1);
    @(posedge clk); #1;
    drive(1'b0, 8'h00, 8'h00, 2'd0, 1'b0, 1'b0);
    check("post_rst_no_early", {63'd0, out_valid}, 64'd0);
    @(posedge clk); #1;
    check("post_rst_valid", {63'd0, out_valid}, 64'd1);
    check("post_rst_y", {56'd0, out_y}, 64'h11);

    // Backpressure: 6 beats with out_ready pattern 1,0,0,1,0,1
    do_reset();
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1; pat[4] = 1'b0; pat[5] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      bp_a[k] = 8'($urandom); bp_b[k] = 8'($urandom);
      bp_op[k] = 2'($urandom); bp_acc[k] = 1'($urandom);
    end
    sent = 0; delivered = 0;
    for (int c = 0; c < 60 && delivered < 6; c++) begin
      out_ready = pat[c % 6];
      if (sent < 6) drive(1'b1, bp_a[sent], bp_b[sent], bp_op[sent], bp_acc[sent], (sent == 2 || sent == 5));
      else          drive(1'b0, 8'h00, 8'h00, 2'd0, 1'b0, 1'b0);
      step(ahs);
      if (ahs) sent++;
    end
    check("bp_sent", sent, 6);
    check("bp_delivered", delivered, 6);
    check("bp_queue_empty", q.size(), 0);

    // Randomised traffic against the reference model
    do_reset();
    delivered = 0;
    for (int c = 0; c < 400; c++) begin
      out_ready = ($urandom_range(0, 2) != 0);
      drive(($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom), 2'($urandom),
            1'($urandom), ($urandom_range(0, 3) == 0));
      step(ahs);
    end
    drive(1'b0, 8'h00, 8'h00, 2'd0, 1'b0, 1'b0);
    out_ready = 1'b1;
    for (int c = 0; c < 10 && q.size() != 0; c++) step(ahs);
    check("rand_drain_empty", q.size(), 0);
    #1;
    check("rand_idle_valid", {63'd0, out_valid}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/logic_reduce_pipe.md
Name: logic_reduce_pipe

Overview:
Parametrised, pipelined bitwise logic unit for the CNN accelerator datapath, for mask gating, activation-sign masking and flag reduction.
- Generalises the two-input single-bit AND gate to WIDTH-bit operands with a selectable operation.
- Adds a frame-based accumulate mode, AND/OR reduction flags and valid/ready flow control.
- Sits between the feature-map buffer and the PE array mask inputs.

Parameters:
- WIDTH, 8, operand/result width in bits (legal range 2..64).

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid && in_ready.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_op  in  2  operation: 00 AND, 01 OR, 10 XOR, 11 NAND.
- in_acc  in  1  1 = replace A by the running accumulator (ignored on the first beat of a frame).
- in_last  in  1  marks the last beat of a frame.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts when out_valid && out_ready.
- out_y  out  WIDTH  result.
- out_all  out  1  AND-reduce of out_y.
- out_any  out  1  OR-reduce of out_y.
- out_last  out  1  in_last delayed with its beat.

Behaviour:
- Reset (synchronous, active-high), applied at any time including mid-frame or mid-stall:
  - Clears both stage valids, so out_valid=0.
  - out_y=0, out_all=0, out_any=0, out_last=0.
  - Accumulator=0; frame FSM to FIRST.
  - in_ready=1 the cycle after rst deasserts.
- Stage 1 (S1) registers the result y, last and valid:
  - Operand select: opA = (state==MID && in_acc) ? acc : in_a.
  - y = opA op in_b; NAND is ~(opA & in_b), full WIDTH.
- Stage 2 (S2) registers y, last, all=&y, any=|y and valid; outputs are driven directly from S2 registers.
- Latency: 2 cycles accept-to-out_valid with no backpressure. Throughput: 1 beat/cycle.
- Flow control:
  - S2 loads when !s2_valid || out_ready.
  - S1 advances into S2 under the same condition.
  - in_ready = !s1_valid || (!s2_valid || out_ready).
  - Outputs hold stable while out_valid && !out_ready.
  - No beat is dropped or duplicated.
- Frame FSM, updated only on an accepted input beat:
  - FIRST -> MID when !in_last.
  - MID -> FIRST when in_last.
  - FIRST with in_last stays FIRST (single-beat frame).
- Accumulator: loads the computed y on every accepted beat, independent of in_acc. It is not cleared at frame end; the next FIRST beat ignores it.
- Simultaneous events:
  - Accept at input and release at output in the same cycle: both occur, with no bubble.
  - in_acc=1 on a FIRST beat: treated as 0.
- in_op, in_acc, in_a, in_b and in_last are sampled only on accept. Values while !in_valid are don't-care.

Optional Feature:
LOGIC_REDUCE_PARITY_EN:
- Defined: adds output port out_parity (1 bit) = ^out_y, registered in S2 with the other flags. Reset value 0.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Decomposition:
- Shared package logic_pkg holds:
  - the op-code localparams (OP_AND=2'b00, OP_OR=2'b01, OP_XOR=2'b10, OP_NAND=2'b11);
  - the frame FSM state encoding (ST_FIRST, ST_MID).
- One natural sub-module, logic_op_core: a combinational opA/in_b/op -> y function, reused by the future multi-lane variant.
- Pipeline registers, FSM and accumulator stay in the top.

Test Plan:
- Vectors at WIDTH=8, out_ready=1:
  - a=0xF0, b=0x3C for each op -> y = AND 0x30, OR 0xFC, XOR 0xCC, NAND 0xCF.
  - Each output appears exactly 2 cycles after accept.
  - NAND gives out_all=0, out_any=1.
- Reduction flags: a=0xFF, b=0xFF, AND -> out_y=0xFF, out_all=1, out_any=1. Then a=0x00, b=0x5A, AND -> out_y=0x00, out_all=0, out_any=0.
- Accumulate frame: beats (a=0xFF, b=0xF7, acc=0), (a=0x00, b=0x7F, acc=1), (a=0x00, b=0xFE, acc=1, last=1), all AND -> out_y 0xF7, 0x77, 0x76, with out_last only on the third beat. A following FIRST beat (a=0x0F, b=0xFF, acc=1, AND) -> 0x0F.
- Backpressure: stream 6 beats with out_ready toggling 1,0,0,1,0,1:
  - all 6 results arrive in order, none lost or repeated;
  - out_y is stable during stalls;
  - in_ready drops to 0 only when both stages are full and out_ready=0.
- Reset mid-frame: assert rst for 1 cycle after the second beat of an accumulate frame, with one beat pending in S2 -> out_valid=0 the next cycle. A subsequent beat (a=0x11, b=0xFF, acc=1, AND) yields 0x11 (FSM back in FIRST).
- With LOGIC_REDUCE_PARITY_EN: a=0x07, b=0xFF, AND -> out_parity=1; a=0x03, b=0xFF -> out_parity=0. Without the macro, elaboration has no out_parity port.
